// File: rtl/tlul_simple_master.sv
// rtl/tlul_simple_master.sv - TL-UL initiator bridging a command/response port onto channels A and D
module tlul_simple_master #(
    parameter int TL_RS       = 4,
    parameter int AW          = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic             tlm_clock_i,
    input  logic             tlm_resetn_i,

    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_write_i,
    input  logic [AW-1:0]    cmd_address_i,
    input  logic [3:0]       cmd_size_i,
    input  logic [3:0]       cmd_mask_i,
    input  logic [31:0]      cmd_data_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_write_o,
    output logic [TL_RS-1:0] rsp_source_o,
    output logic [31:0]      rsp_data_o,
    output logic             rsp_error_o,

    output logic [2:0]       a_opcode,
    output logic [2:0]       a_param,
    output logic [3:0]       a_size,
    output logic [TL_RS-1:0] a_source,
    output logic [AW-1:0]    a_address,
    output logic [3:0]       a_mask,
    output logic [31:0]      a_data,
    output logic             a_corrupt,
    output logic             a_valid,
    input  logic             a_ready,

    input  logic [2:0]       d_opcode,
    input  logic [1:0]       d_param,
    input  logic [3:0]       d_size,
    input  logic [TL_RS-1:0] d_source,
    input  logic             d_denied,
    input  logic [31:0]      d_data,
    input  logic             d_corrupt,
    input  logic             d_valid,
    output logic             d_ready,

    output logic             idle_o,
    output logic             proto_err_o
);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;

    logic [OUTSTANDING-1:0] free_q, free_d;
    logic [OUTSTANDING-1:0] wr_flag_q, wr_flag_d;

    logic             a_valid_q, a_valid_d;
    logic [2:0]       a_opcode_q, a_opcode_d;
    logic [3:0]       a_size_q, a_size_d;
    logic [TL_RS-1:0] a_source_q, a_source_d;
    logic [AW-1:0]    a_address_q, a_address_d;
    logic [3:0]       a_mask_q, a_mask_d;
    logic [31:0]      a_data_q, a_data_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_write_q, rsp_write_d;
    logic [TL_RS-1:0] rsp_source_q, rsp_source_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_error_q, rsp_error_d;
    logic             proto_err_q, proto_err_d;

    logic             any_free;
    logic             cmd_accept;
    logic [TL_RS-1:0] alloc_idx;
    logic             d_fire;
    logic             src_hit;
    logic             src_wr;

    // Channel D opcode/param/size are intentionally ignored; read/write comes from the slot flag.
    logic unused_d_fields;
    assign unused_d_fields = ^{d_opcode, d_param, d_size};

    assign any_free    = |free_q;
    assign cmd_ready_o = (!a_valid_q || a_ready) && any_free;
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;
    assign d_ready     = !rsp_valid_q || rsp_ready_i;
    assign d_fire      = d_valid && d_ready;

    always_comb begin
        alloc_idx = '0;
        for (int i = OUTSTANDING - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_idx = i[TL_RS-1:0];
        end
    end

    // A source is only legitimate if it indexes an existing slot that is currently busy.
    always_comb begin
        src_hit = 1'b0;
        src_wr  = 1'b0;
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (d_source == i[TL_RS-1:0] && !free_q[i]) begin
                src_hit = 1'b1;
                src_wr  = wr_flag_q[i];
            end
        end
    end

    always_comb begin
        free_d    = free_q;
        wr_flag_d = wr_flag_q;
        if (cmd_accept) begin
            free_d[alloc_idx]    = 1'b0;
            wr_flag_d[alloc_idx] = cmd_write_i;
        end
        if (d_fire && src_hit) free_d[d_source] = 1'b1;
    end

    always_comb begin
        a_valid_d   = a_valid_q;
        a_opcode_d  = a_opcode_q;
        a_size_d    = a_size_q;
        a_source_d  = a_source_q;
        a_address_d = a_address_q;
        a_mask_d    = a_mask_q;
        a_data_d    = a_data_q;
        if (cmd_accept) begin
            a_valid_d   = 1'b1;
            a_size_d    = cmd_size_i;
            a_source_d  = alloc_idx;
            a_address_d = cmd_address_i;
            a_mask_d    = cmd_mask_i;
            a_data_d    = cmd_data_i;
            if (!cmd_write_i)
                a_opcode_d = OP_GET;
            else if (cmd_size_i == 4'd2 && cmd_mask_i == 4'hF)
                a_opcode_d = OP_PUT_FULL;
            else
                a_opcode_d = OP_PUT_PART;
        end else if (a_ready) begin
            a_valid_d = 1'b0;
        end
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_write_d  = rsp_write_q;
        rsp_source_d = rsp_source_q;
        rsp_data_d   = rsp_data_q;
        rsp_error_d  = rsp_error_q;
        proto_err_d  = proto_err_q;
        if (d_fire) begin
            rsp_valid_d  = 1'b1;
            rsp_write_d  = src_hit && src_wr;
            rsp_source_d = d_source;
            rsp_data_d   = d_data;
            rsp_error_d  = d_denied || d_corrupt || !src_hit;
            if (!src_hit) proto_err_d = 1'b1;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge tlm_clock_i or negedge tlm_resetn_i) begin
        if (!tlm_resetn_i) begin
            free_q       <= '1;
            wr_flag_q    <= '0;
            a_valid_q    <= 1'b0;
            a_opcode_q   <= '0;
            a_size_q     <= '0;
            a_source_q   <= '0;
            a_address_q  <= '0;
            a_mask_q     <= '0;
            a_data_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_source_q <= '0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            free_q       <= free_d;
            wr_flag_q    <= wr_flag_d;
            a_valid_q    <= a_valid_d;
            a_opcode_q   <= a_opcode_d;
            a_size_q     <= a_size_d;
            a_source_q   <= a_source_d;
            a_address_q  <= a_address_d;
            a_mask_q     <= a_mask_d;
            a_data_q     <= a_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_write_q  <= rsp_write_d;
            rsp_source_q <= rsp_source_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign a_valid      = a_valid_q;
    assign a_opcode     = a_opcode_q;
    assign a_param      = 3'd0;
    assign a_size       = a_size_q;
    assign a_source     = a_source_q;
    assign a_address    = a_address_q;
    assign a_mask       = a_mask_q;
    assign a_data       = a_data_q;
    assign a_corrupt    = 1'b0;

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_write_o  = rsp_write_q;
    assign rsp_source_o = rsp_source_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_error_o  = rsp_error_q;
    assign proto_err_o  = proto_err_q;
    assign idle_o       = (&free_q) && !a_valid_q;

endmodule

// File: tb/tb_tlul_simple_master.sv
// tb/tb_tlul_simple_master.sv - directed self-checking bench for tlul_simple_master
module tb_tlul_simple_master;

    localparam int TL_RS = 4;
    localparam int AW    = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]    cmd_address;
    logic [3:0]       cmd_size, cmd_mask;
    logic [31:0]      cmd_data;
    logic             rsp_valid, rsp_ready, rsp_write, rsp_error;
    logic [TL_RS-1:0] rsp_source;
    logic [31:0]      rsp_data;
    logic [2:0]       a_opcode, a_param;
    logic [3:0]       a_size, a_mask;
    logic [TL_RS-1:0] a_source;
    logic [AW-1:0]    a_address;
    logic [31:0]      a_data;
    logic             a_corrupt, a_valid, a_ready;
    logic [2:0]       d_opcode;
    logic [1:0]       d_param;
    logic [3:0]       d_size;
    logic [TL_RS-1:0] d_source;
    logic             d_denied, d_corrupt, d_valid, d_ready;
    logic [31:0]      d_data;
    logic             idle, proto_err;

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    int beats_before;

    tlul_simple_master #(.TL_RS(TL_RS), .AW(AW), .OUTSTANDING(4)) dut (
        .tlm_clock_i(clk), .tlm_resetn_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_address_i(cmd_address), .cmd_size_i(cmd_size), .cmd_mask_i(cmd_mask),
        .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
        .rsp_source_o(rsp_source), .rsp_data_o(rsp_data), .rsp_error_o(rsp_error),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
        .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
        .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt), .d_valid(d_valid),
        .d_ready(d_ready),
        .idle_o(idle), .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && a_valid && a_ready) beats <= beats + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven mid-cycle, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_address = '0; cmd_size = '0;
        cmd_mask = '0; cmd_data = '0; rsp_ready = 1; a_ready = 1;
        d_opcode = '0; d_param = '0; d_size = '0; d_source = '0;
        d_denied = 0; d_data = '0; d_corrupt = 0; d_valid = 0;
    endtask

    task automatic d_beat(input logic [TL_RS-1:0] src, input logic [31:0] data);
        d_valid = 1; d_source = src; d_data = data; d_opcode = 3'd1;
    endtask

    initial begin
        // 1: reset with random inputs
        rst_n = 0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_address = $urandom;
            cmd_size = 4'($urandom); cmd_mask = 4'($urandom); cmd_data = $urandom;
            rsp_ready = 1'($urandom); a_ready = 1'($urandom); d_valid = 1'($urandom);
            d_source = TL_RS'($urandom); d_data = $urandom; d_opcode = 3'($urandom);
            d_param = 2'($urandom); d_size = 4'($urandom);
            d_denied = 1'($urandom); d_corrupt = 1'($urandom);
            tick();
            check_eq("rst_a_valid", a_valid, 0);
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_proto_err", proto_err, 0);
        end
        idle_inputs();
        rst_n = 1;
        tick();
        check_eq("rel_idle", idle, 1);
        check_eq("rel_cmd_ready", cmd_ready, 1);
        check_eq("rel_a_valid", a_valid, 0);

        // 2: single PutFullData and its response
        cmd_valid = 1; cmd_write = 1; cmd_address = 32'h4; cmd_data = 32'hDEADBEEF;
        cmd_mask = 4'hF; cmd_size = 4'd2;
        settle();
        check_eq("t2_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 0;
        check_eq("t2_a_valid", a_valid, 1);
        check_eq("t2_a_opcode", a_opcode, 0);
        check_eq("t2_a_source", a_source, 0);
        check_eq("t2_a_address", a_address, 32'h4);
        check_eq("t2_a_data", a_data, 32'hDEADBEEF);
        check_eq("t2_a_param", a_param, 0);
        check_eq("t2_a_corrupt", a_corrupt, 0);
        check_eq("t2_idle_busy", idle, 0);
        d_beat(0, 32'h0);
        settle();
        check_eq("t2_d_ready", d_ready, 1);
        tick();
        d_valid = 0;
        check_eq("t2_a_valid_drop", a_valid, 0);
        check_eq("t2_rsp_valid", rsp_valid, 1);
        check_eq("t2_rsp_write", rsp_write, 1);
        check_eq("t2_rsp_source", rsp_source, 0);
        check_eq("t2_rsp_error", rsp_error, 0);
        check_eq("t2_idle", idle, 1);
        tick();
        check_eq("t2_rsp_drained", rsp_valid, 0);

        // 3: fill all four slots, fifth read waits for a free slot
        cmd_valid = 1; cmd_write = 0; cmd_mask = 4'hF; cmd_size = 4'd2;
        for (int i = 0; i < 4; i++) begin
            cmd_address = 32'h100 + 32'(i * 4);
            settle();
            check_eq("t3_cmd_ready", cmd_ready, 1);
            tick();
            check_eq("t3_a_source", a_source, 64'(i));
            check_eq("t3_a_opcode", a_opcode, 4);
        end
        cmd_address = 32'h200;
        settle();
        check_eq("t3_full_cmd_ready", cmd_ready, 0);
        d_beat(2, 32'hCAFE0002);
        tick();
        d_valid = 0;
        check_eq("t3_rsp_source", rsp_source, 2);
        check_eq("t3_rsp_write", rsp_write, 0);
        check_eq("t3_rsp_data", rsp_data, 32'hCAFE0002);
        check_eq("t3_reuse_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 0;
        check_eq("t3_fifth_source", a_source, 2);
        check_eq("t3_fifth_addr", a_address, 32'h200);
        d_beat(0, 0); tick();
        d_beat(1, 0); tick();
        d_beat(3, 0); tick();
        d_beat(2, 0); tick();
        d_valid = 0;
        tick();
        check_eq("t3_idle", idle, 1);
        check_eq("t3_proto_err", proto_err, 0);

        // 4: PutPartialData held under back-pressure
        a_ready = 0;
        cmd_valid = 1; cmd_write = 1; cmd_size = 4'd1; cmd_mask = 4'b0011;
        cmd_address = 32'h10; cmd_data = 32'h1234;
        beats_before = beats;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("t4_a_valid", a_valid, 1);
            check_eq("t4_a_fields", {a_opcode, a_size, a_mask, a_source, a_address, a_data},
                     {3'd1, 4'd1, 4'b0011, 4'd0, 32'h10, 32'h1234});
            check_eq("t4_stall_cmd_ready", cmd_ready, 0);
            tick();
        end
        a_ready = 1;
        tick();
        check_eq("t4_a_valid_drop", a_valid, 0);
        check_eq("t4_beats", 64'(beats - beats_before), 1);
        d_beat(0, 0);
        tick();
        d_valid = 0;
        check_eq("t4_rsp_write", rsp_write, 1);
        tick();

        // 5: response back-pressure with out-of-order returns
        cmd_valid = 1; cmd_write = 0; cmd_size = 4'd2; cmd_mask = 4'hF;
        tick();
        tick();
        cmd_valid = 0;
        check_eq("t5_second_source", a_source, 1);
        rsp_ready = 0;
        d_beat(1, 32'h11);
        settle();
        check_eq("t5_d_ready_first", d_ready, 1);
        tick();
        d_beat(0, 32'h22);
        settle();
        check_eq("t5_d_ready_blocked", d_ready, 0);
        check_eq("t5_rsp1_data", rsp_data, 32'h11);
        check_eq("t5_rsp1_source", rsp_source, 1);
        tick();
        check_eq("t5_rsp1_held", rsp_data, 32'h11);
        rsp_ready = 1;
        settle();
        check_eq("t5_d_ready_release", d_ready, 1);
        tick();
        d_valid = 0;
        check_eq("t5_rsp2_valid", rsp_valid, 1);
        check_eq("t5_rsp2_data", rsp_data, 32'h22);
        check_eq("t5_rsp2_source", rsp_source, 0);
        tick();
        check_eq("t5_idle", idle, 1);
        check_eq("t5_rsp_empty", rsp_valid, 0);

        // 6: unexpected source, then reset mid-burst
        d_beat(7, 32'h77);
        tick();
        d_valid = 0;
        check_eq("t6_rsp_valid", rsp_valid, 1);
        check_eq("t6_rsp_error", rsp_error, 1);
        check_eq("t6_rsp_write", rsp_write, 0);
        check_eq("t6_proto_err", proto_err, 1);
        check_eq("t6_idle", idle, 1);
        tick(); tick();
        check_eq("t6_proto_sticky", proto_err, 1);
        check_eq("t6_cmd_ready", cmd_ready, 1);
        a_ready = 0;
        cmd_valid = 1;
        tick();
        d_beat(3, 32'h33);
        tick();
        check_eq("t6_busy_a_valid", a_valid, 1);
        rst_n = 0;
        settle();
        check_eq("t6_rst_a_valid", a_valid, 0);
        check_eq("t6_rst_rsp_valid", rsp_valid, 0);
        check_eq("t6_rst_proto_err", proto_err, 0);
        check_eq("t6_rst_idle", idle, 1);
        idle_inputs();
        tick();
        rst_n = 1;
        tick();
        check_eq("t6_post_cmd_ready", cmd_ready, 1);
        check_eq("t6_post_rsp_valid", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
